lpc_host: RTL and testbench
===========================

# lpc_host

Minimal LPC host (initiator) that issues single-byte TPM I/O read and write cycles on an LPC bus, the opposite end of the `lpc_periph` + `regs_module` data path. It drives LFRAME#/LAD from a simple request/response port and checks SYNC, with a timeout. It serves as the bus-functional initiator in TwPM bring-up benches and as a synthesizable host for loopback tests on the OrangeCrab.

## Interface
- `SYNC_TIMEOUT`, 8: max clocks spent in SYNC without a ready (0000) or error (1010) nibble; long wait (0110) is exempt.
- `clk_i`  in  1  LPC clock (LCLK); all logic on rising edge.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request strobe; sampled only in IDLE.
- `wr_i`  in  1  1 = I/O write, 0 = I/O read; latched with `start_i`.
- `addr_i`  in  16  I/O address; latched with `start_i`.
- `data_i`  in  8  write data; latched with `start_i`.
- `data_o`  out  8  read data; valid while `done_o`=1, then held.
- `busy_o`  out  1  cycle in progress.
- `done_o`  out  1  one-clock completion pulse.
- `err_o`  out  1  qualifies `done_o`: SYNC error or timeout.
- `lframe_o`  out  1  LFRAME#.
- `lad_o`  out  4  LAD drive value.
- `lad_oe`  out  1  LAD output enable; pad tri-state is external.
- `lad_i`  in  4  LAD sampled value.

## Operation
- Reset values: `lframe_o`=1, `lad_o`=4'hF, `lad_oe`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `data_o`=8'h00, state IDLE. Reset mid-cycle releases the bus on the asynchronous edge; no abort is sent.
- States: IDLE, START, CYCTYPE, ADDR0-3, WDATA0-1, HTAR0-1, SYNC, RDATA0-1, PTAR0-1, DONE, ABORT (macro only).
- IDLE: `start_i`=1 latches `wr_i`, `addr_i`, `data_i`, sets `busy_o`, and enters START. `start_i` while `busy_o`=1 is ignored.
- START: `lframe_o`=0, `lad_o`=4'b0101 (TPM start), `lad_oe`=1.
- CYCTYPE: `lad_o`=4'b0010 for a write or 4'b0000 for a read.
- ADDR0-3: address nibbles, MSB nibble first.
- WDATA0-1 (write only): low nibble, then high nibble.
- HTAR0: drive 4'hF. HTAR1: `lad_oe`=0. The host does not drive LAD from here to the end of the cycle.
- SYNC, one nibble per clock from `lad_i`:
  - 0000 (ready): go to RDATA0 for a read, PTAR0 for a write.
  - 1010 (error): same path, with the error flag set.
  - 0101 (short wait) or any other value: stay and increment the timeout counter.
  - 0110 (long wait): stay; the counter is cleared and held.
  - Counter reaching `SYNC_TIMEOUT` sets the error flag and goes to ABORT, or to DONE if the abort feature is not compiled in.
- RDATA0-1: capture low nibble, then high nibble, into `data_o`.
- PTAR0-1: peripheral turnaround, ignored.
- DONE: `done_o`=1 and `err_o`=flag for one clock, `busy_o`=0, then IDLE. The next request is accepted on the following clock.

## Timing
- Zero-wait write or read: `start_i` sampled at edge 0, START driven after edge 0, `done_o` high after edge 14.
  - Bus occupancy is 13 LCLKs: 1 START + 1 CYCTYPE + 4 ADDR + 2 DATA or TAR + 2 TAR/DATA + 1 SYNC + 2 TAR.
- Each wait nibble adds one clock.
- Timeout: exactly `SYNC_TIMEOUT` consecutive non-terminal, non-long-wait nibbles.
- `data_o` updates only in RDATA states; writes leave it unchanged.

## Configuration
- `LPC_HOST_ABORT_EN` defined: on timeout, ABORT drives `lframe_o`=0, `lad_o`=4'hF, `lad_oe`=1 for 4 clocks, then 1 clock with `lframe_o`=1 and `lad_oe`=0, then DONE with `err_o`=1.
- Not defined: timeout goes directly to DONE with `err_o`=1; `lframe_o` stays high and LAD stays released.

## Test plan
- Write 0x0F00 ← 0xA5, zero-wait peripheral:
  - LAD sequence 5,2,0,F,0,0,5,A,F,(Z),0,(Z,Z).
  - `lframe_o` low only in the first bus clock.
  - `done_o`=1 and `err_o`=0 at clock 14.
- Read 0x0F24, peripheral answers 0101, 0101, 0000, then 0xC, 0x3:
  - `data_o`=8'h3C, `err_o`=0.
  - `done_o` at clock 16.
- Write with SYNC 1010: completes normally, `done_o` with `err_o`=1 at clock 14.
- No peripheral (lad_i=4'hF), `SYNC_TIMEOUT`=8:
  - With the macro: 4 clocks of LFRAME# low with LAD=F, then `err_o`=1.
  - Without the macro: `done_o`/`err_o` 9 clocks after entering SYNC.
- Long wait 0110 held for 40 clocks, then 0000: no timeout, `err_o`=0.
- `start_i` pulsed mid-cycle is ignored. `rstn_i` low during ADDR1 immediately forces `lframe_o`=1 and `lad_oe`=0, with `busy_o`=0 and `done_o`=0.

Source files
------------

// File: rtl/lpc_host.sv
// ---------------------------------------------------------------------------
// lpc_host
// Minimal LPC initiator issuing single-byte TPM I/O read/write cycles.
// A request is latched from a simple strobe interface, serialised onto
// LFRAME#/LAD, and the peripheral's SYNC nibble is checked. Wait states are
// tolerated, with a timeout on short-wait or unrecognised nibbles.
//
// Optional feature: define LPC_HOST_ABORT_EN to send an LPC abort
// (LFRAME# low with LAD=F for 4 clocks) after a SYNC timeout. Without it a
// timeout simply ends the cycle with an error and leaves the bus released.
//
// Ports
//   clk_i      LPC clock (LCLK), all logic on the rising edge
//   rstn_i     asynchronous active-low reset
//   start_i    request strobe, sampled only while idle
//   wr_i       1 = I/O write, 0 = I/O read (latched with start_i)
//   addr_i     16-bit I/O address (latched with start_i)
//   data_i     write data (latched with start_i)
//   data_o     read data, valid with done_o and held afterwards
//   busy_o     cycle in progress
//   done_o     one-clock completion pulse
//   err_o      qualifies done_o: SYNC error or timeout
//   lframe_o   LFRAME#
//   lad_o      LAD drive value
//   lad_oe     LAD output enable (pad tri-state is external)
//   lad_i      LAD sampled value
// ---------------------------------------------------------------------------
module lpc_host #(
    parameter int SYNC_TIMEOUT = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        wr_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        lframe_o,
    output logic [3:0]  lad_o,
    output logic        lad_oe,
    input  logic [3:0]  lad_i
);

    localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [4:0] {
        IDLE, START, CYCTYPE, ADDR0, ADDR1, ADDR2, ADDR3,
        WDATA0, WDATA1, HTAR0, HTAR1, SYNC, RDATA0, RDATA1,
        PTAR0, PTAR1, DONE, ABORT
    } state_t;

    state_t             state;
    logic               wr_q;
    logic [15:0]        addr_q;
    logic [7:0]         wdata_q;
    logic               err_flag;
    logic [CNT_W-1:0]   sync_cnt;
`ifdef LPC_HOST_ABORT_EN
    logic [2:0]         abort_cnt;
`endif

    // Bus outputs are registered: each transition loads the values that
    // belong to the state being entered, so LAD/LFRAME# change exactly on
    // the clock edge that starts the corresponding bus clock.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            err_flag <= 1'b0;
            sync_cnt <= '0;
            data_o   <= 8'h00;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            lframe_o <= 1'b1;
            lad_o    <= 4'hF;
            lad_oe   <= 1'b0;
`ifdef LPC_HOST_ABORT_EN
            abort_cnt <= 3'd0;
`endif
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        wr_q     <= wr_i;
                        addr_q   <= addr_i;
                        wdata_q  <= data_i;
                        err_flag <= 1'b0;
                        busy_o   <= 1'b1;
                        lframe_o <= 1'b0;
                        lad_o    <= 4'b0101;
                        lad_oe   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    lframe_o <= 1'b1;
                    lad_o    <= wr_q ? 4'b0010 : 4'b0000;
                    state    <= CYCTYPE;
                end
                CYCTYPE: begin
                    lad_o <= addr_q[15:12];
                    state <= ADDR0;
                end
                ADDR0: begin
                    lad_o <= addr_q[11:8];
                    state <= ADDR1;
                end
                ADDR1: begin
                    lad_o <= addr_q[7:4];
                    state <= ADDR2;
                end
                ADDR2: begin
                    lad_o <= addr_q[3:0];
                    state <= ADDR3;
                end
                ADDR3: begin
                    if (wr_q) begin
                        lad_o <= wdata_q[3:0];
                        state <= WDATA0;
                    end else begin
                        lad_o <= 4'hF;
                        state <= HTAR0;
                    end
                end
                WDATA0: begin
                    lad_o <= wdata_q[7:4];
                    state <= WDATA1;
                end
                WDATA1: begin
                    lad_o <= 4'hF;
                    state <= HTAR0;
                end
                HTAR0: begin
                    // Release LAD for the rest of the cycle.
                    lad_oe <= 1'b0;
                    state  <= HTAR1;
                end
                HTAR1: begin
                    sync_cnt <= '0;
                    state    <= SYNC;
                end
                SYNC: begin
                    case (lad_i)
                        4'b0000: state <= wr_q ? PTAR0 : RDATA0;
                        4'b1010: begin
                            err_flag <= 1'b1;
                            state    <= wr_q ? PTAR0 : RDATA0;
                        end
                        // Long wait is exempt from the timeout.
                        4'b0110: sync_cnt <= '0;
                        default: begin
                            if (sync_cnt == CNT_W'(SYNC_TIMEOUT - 1)) begin
                                err_flag <= 1'b1;
`ifdef LPC_HOST_ABORT_EN
                                lframe_o  <= 1'b0;
                                lad_o     <= 4'hF;
                                lad_oe    <= 1'b1;
                                abort_cnt <= 3'd0;
                                state     <= ABORT;
`else
                                state     <= DONE;
`endif
                            end else begin
                                sync_cnt <= sync_cnt + CNT_W'(1);
                            end
                        end
                    endcase
                end
                RDATA0: begin
                    data_o[3:0] <= lad_i;
                    state       <= RDATA1;
                end
                RDATA1: begin
                    data_o[7:4] <= lad_i;
                    state       <= PTAR0;
                end
                PTAR0: state <= PTAR1;
                PTAR1: state <= DONE;
                DONE: begin
                    done_o <= 1'b1;
                    err_o  <= err_flag;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
`ifdef LPC_HOST_ABORT_EN
                // Four clocks of LFRAME# low, then one clock of released bus.
                ABORT: begin
                    if (abort_cnt == 3'd3) begin
                        lframe_o <= 1'b1;
                        lad_oe   <= 1'b0;
                    end
                    if (abort_cnt == 3'd4) begin
                        state <= DONE;
                    end
                    abort_cnt <= abort_cnt + 3'd1;
                end
`endif
                default: begin
                    lframe_o <= 1'b1;
                    lad_oe   <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_host.sv
// ---------------------------------------------------------------------------
// tb_lpc_host
// Bench for lpc_host. A table of transactions is driven through the host
// while a scheduled peripheral model answers on lad_i (short waits, long
// waits, terminal SYNC nibble, read data). Expected completions are queued
// at request time and popped when done_o pulses. Hand-written sequences
// cover reset, the write bus pattern, start_i while busy and reset mid-cycle.
// Set LPC_HOST_ABORT_EN to match the RTL build.
// ---------------------------------------------------------------------------
module tb_lpc_host;

    logic        clk_i;
    logic        rstn_i;
    logic        start_i;
    logic        wr_i;
    logic [15:0] addr_i;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        lframe_o;
    logic [3:0]  lad_o;
    logic        lad_oe;
    logic [3:0]  lad_i;

    lpc_host #(.SYNC_TIMEOUT(8)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .start_i  (start_i),
        .wr_i     (wr_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .lframe_o (lframe_o),
        .lad_o    (lad_o),
        .lad_oe   (lad_oe),
        .lad_i    (lad_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One transaction: request fields, peripheral SYNC script, and the
    // hand-derived completion clock for each build flavour.
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          pre;
        int          lng;
        int          post;
        logic [3:0]  term;
        logic [7:0]  rdata;
        logic        exp_err;
        int          cyc_plain;
        int          cyc_abort;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
        int         lframe_low;
    } exp_t;

    vec_t       vecs[9];
    exp_t       exp_q[$];
    logic [7:0] model_data;
    int         n_compared;
    int         n_mismatch;

`ifdef LPC_HOST_ABORT_EN
    localparam bit ABORT_BUILD = 1'b1;
`else
    localparam bit ABORT_BUILD = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Peripheral answer for bus clock k (clock k follows edge k after start).
    function automatic logic [3:0] periphNibble(input vec_t v, input int k);
        int idx;
        int len;
        idx = k - (v.wr ? 10 : 8);
        len = v.pre + v.lng + v.post;
        if (idx < 0)                return 4'hF;
        if (idx < v.pre)            return 4'b0101;
        if (idx < v.pre + v.lng)    return 4'b0110;
        if (idx < len)              return 4'b0101;
        if (idx == len)             return v.term;
        if (v.term != 4'hF && !v.wr && idx == len + 1) return v.rdata[3:0];
        if (v.term != 4'hF && !v.wr && idx == len + 2) return v.rdata[7:4];
        return 4'hF;
    endfunction

    task automatic applyStimulus(input vec_t v, input bit check_bus, input bit pulse_start);
        exp_t       e;
        exp_t       got;
        bit         timeout;
        bit         seen;
        int         done_k;
        int         extra_low;
        logic [3:0] exp_nib[9];

        timeout = (v.term == 4'hF);
        if (!v.wr && !timeout) model_data = v.rdata;
        e.data       = model_data;
        e.err        = v.exp_err;
        e.cyc        = ABORT_BUILD ? v.cyc_abort : v.cyc_plain;
        e.lframe_low = (timeout && ABORT_BUILD) ? 4 : 0;
        exp_q.push_back(e);

        exp_nib[0] = 4'b0101;
        exp_nib[1] = v.wr ? 4'b0010 : 4'b0000;
        exp_nib[2] = v.addr[15:12];
        exp_nib[3] = v.addr[11:8];
        exp_nib[4] = v.addr[7:4];
        exp_nib[5] = v.addr[3:0];
        exp_nib[6] = v.wdata[3:0];
        exp_nib[7] = v.wdata[7:4];
        exp_nib[8] = 4'hF;

        @(negedge clk_i);
        start_i = 1'b1;
        wr_i    = v.wr;
        addr_i  = v.addr;
        data_i  = v.wdata;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;

        seen      = 1'b0;
        done_k    = 0;
        extra_low = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (check_bus && k < 13) begin
                checkOutput($sformatf("lframe_clk%0d", k), {31'd0, lframe_o}, (k == 0) ? 32'd0 : 32'd1);
                checkOutput($sformatf("lad_oe_clk%0d", k), {31'd0, lad_oe}, (k < 9) ? 32'd1 : 32'd0);
                if (k < 9) checkOutput($sformatf("lad_clk%0d", k), {28'd0, lad_o}, {28'd0, exp_nib[k]});
            end
            if (k > 0 && !lframe_o) extra_low++;
            if (pulse_start && k == 4) begin
                start_i = 1'b1;
                wr_i    = ~v.wr;
                addr_i  = 16'hDEAD;
                data_i  = 8'h11;
            end
            if (k == 5) start_i = 1'b0;
            lad_i = periphNibble(v, k);
            @(posedge clk_i);
            #1;
            if (done_o) begin
                seen   = 1'b1;
                done_k = k + 1;
            end
        end
        lad_i = 4'hF;

        if (!seen) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL done_wait: got no done_o within 200 clocks, expected done at clock %0d", e.cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL scoreboard: got done_o with empty queue, expected none");
        end else begin
            got = exp_q.pop_front();
            checkOutput("done_cycle", done_k, got.cyc);
            checkOutput("err",        {31'd0, err_o}, {31'd0, got.err});
            checkOutput("data",       {24'd0, data_o}, {24'd0, got.data});
            checkOutput("busy_at_done", {31'd0, busy_o}, 32'd0);
            checkOutput("lframe_low_clks", extra_low, got.lframe_low);
            @(posedge clk_i);
            #1;
            checkOutput("done_one_clock", {31'd0, done_o}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idle_events;

        n_compared = 0;
        n_mismatch = 0;
        model_data = 8'h00;

        //           wr    addr      wdata  pre lng post term   rdata  err plain abort
        vecs[0] = '{1'b1, 16'h0F00, 8'hA5, 0, 0,  0, 4'h0, 8'h00, 1'b0, 14, 14};
        vecs[1] = '{1'b0, 16'h0F24, 8'h00, 2, 0,  0, 4'h0, 8'h3C, 1'b0, 16, 16};
        vecs[2] = '{1'b1, 16'h1234, 8'h5A, 0, 0,  0, 4'hA, 8'h00, 1'b1, 14, 14};
        vecs[3] = '{1'b0, 16'hABCD, 8'h00, 7, 0,  0, 4'h0, 8'h81, 1'b0, 21, 21};
        vecs[4] = '{1'b0, 16'h0000, 8'h00, 0, 40, 0, 4'h0, 8'h7E, 1'b0, 54, 54};
        vecs[5] = '{1'b1, 16'hFFFF, 8'h00, 5, 1,  5, 4'h0, 8'h00, 1'b0, 25, 25};
        vecs[6] = '{1'b0, 16'h0F00, 8'h00, 0, 0,  0, 4'hA, 8'h99, 1'b1, 14, 14};
        vecs[7] = '{1'b1, 16'h0F10, 8'hC3, 0, 0,  0, 4'hF, 8'h00, 1'b1, 19, 24};
        vecs[8] = '{1'b0, 16'h0F20, 8'h00, 0, 0,  0, 4'hF, 8'h00, 1'b1, 17, 22};

        rstn_i  = 1'b0;
        start_i = 1'b0;
        wr_i    = 1'b0;
        addr_i  = 16'h0000;
        data_i  = 8'h00;
        lad_i   = 4'hF;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_lframe", {31'd0, lframe_o}, 32'd1);
        checkOutput("rst_lad",    {28'd0, lad_o},   32'hF);
        checkOutput("rst_lad_oe", {31'd0, lad_oe},  32'd0);
        checkOutput("rst_busy",   {31'd0, busy_o},  32'd0);
        checkOutput("rst_done",   {31'd0, done_o},  32'd0);
        checkOutput("rst_err",    {31'd0, err_o},   32'd0);
        checkOutput("rst_data",   {24'd0, data_o},  32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], (i == 0), (i == 1));
        end

        // A request pulsed during vecs[1] must not have started another cycle.
        idle_events = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i);
            #1;
            if (busy_o || done_o) idle_events++;
        end
        checkOutput("no_spurious_cycle", idle_events, 0);

        // Reset asserted while the host drives ADDR1.
        @(negedge clk_i);
        start_i = 1'b1;
        wr_i    = 1'b1;
        addr_i  = 16'h4321;
        data_i  = 8'h77;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("addr1_lad_oe", {31'd0, lad_oe}, 32'd1);
        checkOutput("addr1_lad",    {28'd0, lad_o},  32'h3);
        #2;
        rstn_i = 1'b0;
        #1;
        checkOutput("midrst_lframe", {31'd0, lframe_o}, 32'd1);
        checkOutput("midrst_lad_oe", {31'd0, lad_oe},   32'd0);
        checkOutput("midrst_busy",   {31'd0, busy_o},   32'd0);
        checkOutput("midrst_done",   {31'd0, done_o},   32'd0);
        model_data = 8'h00;
        @(negedge clk_i);
        rstn_i = 1'b1;

        applyStimulus(vecs[1], 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
